irrigation_scheduler: RTL and testbench
=======================================

IRRIGATION_SCHEDULER -- requirements
Module: irrigation_scheduler

Interface
REQ-001 Parameter NUM_ZONES, default 4, SHALL set the number of irrigation zones and valve outputs.
REQ-002 Parameter TIMER_W, default 4, SHALL set the width of the per-zone duration and of the tick timer.
REQ-003 Port clk, input, 1: the single clock; all logic SHALL be rising-edge triggered.
REQ-004 Port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port tick, input, 1: timebase strobe, one cycle wide; it is the unit of irrigation time.
REQ-006 Port start, input, 1: request a watering run; sampled only in IDLE.
REQ-007 Port abort, input, 1: terminate the current run.
REQ-008 Port zone_req, input, NUM_ZONES: per-zone dry flags; sampled on an accepted start.
REQ-009 Port duration, input, TIMER_W: ticks of watering per zone; sampled on an accepted start.
REQ-010 Port water_ok, input, 1: reservoir level adequate.
REQ-011 Port valve, output, NUM_ZONES: one-hot or zero valve drive.
REQ-012 Port pump, output, 1: pump drive.
REQ-013 Port busy, output, 1: high in every state except IDLE.
REQ-014 Port done, output, 1: one-cycle pulse on normal run completion.
REQ-015 Port fault, output, 1: sticky water-shortage flag.
REQ-016 Port cur_zone, output, $clog2(NUM_ZONES): index of the zone being served; holds its last value otherwise.

Function
REQ-017 The FSM SHALL have states IDLE, SELECT, RUN, CLOSE and DONE; all outputs SHALL be registered (Moore).
REQ-018 IDLE, start=1, water_ok=1: SHALL latch zone_req into a pending mask and duration into dur_reg, clear fault, and go to SELECT.
REQ-019 IDLE, start=1, water_ok=0: SHALL set fault and stay in IDLE; no valve SHALL open.
REQ-020 SELECT: SHALL pick the first pending zone searching upward from rr_ptr with wrap, clear its pending bit, load cur_zone, clear the timer, and go to RUN.
REQ-021 SELECT with the mask empty, or dur_reg=0: SHALL go to DONE with no valve opened.
REQ-022 RUN: valve[cur_zone]=1 and pump=1; the timer SHALL increment only on cycles with tick=1.
REQ-023 RUN, tick=1 and timer==dur_reg-1: SHALL go to CLOSE, so the valve sees exactly dur_reg ticks.
REQ-024 CLOSE: SHALL last one cycle with valve=0 and pump=0 (break-before-make), set rr_ptr=(cur_zone+1) mod NUM_ZONES, then go to SELECT.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE.
REQ-026 abort=1 in any non-IDLE state: SHALL go to IDLE next cycle with valve=0 and pump=0, clear the pending mask, and assert no done; abort SHALL take priority over the water_ok check.
REQ-027 water_ok=0 in RUN: SHALL set fault, force valve=0 and pump=0, and go to IDLE without done.
REQ-028 start while busy SHALL be ignored; zone_req and duration changes mid-run SHALL have no effect.
REQ-029 At most one valve bit SHALL ever be high; pump SHALL be high only in RUN.

Reset
REQ-030 While reset=0: state=IDLE, valve=0, pump=0, busy=0, done=0, fault=0, cur_zone=0, rr_ptr=0, timer=0, pending mask=0, dur_reg=0.
REQ-031 Reset asserted mid-RUN SHALL close all valves asynchronously, without waiting for a clock edge.

Structure
REQ-032 Package irrigation_pkg SHALL hold the state enum typedef and the NUM_ZONES and TIMER_W defaults.
REQ-033 Sub-module zone_timer SHALL implement the TIMER_W up-counter with enable (tick), synchronous clear and asynchronous active-low reset.

Verification
REQ-034 Reset: assert reset=0 mid-RUN -> valve=0000, pump=0, busy=0, fault=0 immediately.
REQ-035 Normal run: zone_req=0101, duration=3, tick every 4 cycles -> valve=0001 for 3 ticks, one cycle 0000, valve=0100 for 3 ticks, one done pulse, then busy=0.
REQ-036 Round-robin: previous run ends on zone 2; then zone_req=1111, duration=1 -> zones served in order 3, 0, 1, 2.
REQ-037 Abort: abort=1 during zone 1 -> valve=0000 and pump=0 next cycle, no done pulse, busy=0.
REQ-038 Water shortage: water_ok=0 in RUN -> fault=1, valves off, IDLE; a later start with water_ok=1 -> fault=0 and the run proceeds.
REQ-039 Empty run: zone_req=0000 or duration=0 -> done pulse with no valve activity.

Source files
------------

// File: rtl/irrigation_pkg.sv
// Shared defaults and FSM state type for the irrigation scheduler.
package irrigation_pkg;

  localparam int unsigned NUM_ZONES_DEF = 4;
  localparam int unsigned TIMER_W_DEF   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_RUN    = 3'd2,
    ST_CLOSE  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/zone_timer.sv
// Per-zone watering timer: tick-enabled up-counter with synchronous clear.
module zone_timer
  import irrigation_pkg::*;
#(
  parameter int unsigned W = TIMER_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Clear wins over enable so a fresh zone always starts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/irrigation_scheduler.sv
// Round-robin irrigation sequencer: waters each requested zone for a fixed
// number of ticks, with break-before-make between zones and water interlock.
module irrigation_scheduler
  import irrigation_pkg::*;
#(
  parameter int unsigned NUM_ZONES = NUM_ZONES_DEF,
  parameter int unsigned TIMER_W   = TIMER_W_DEF,
  localparam int unsigned ZW       = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_ZONES-1:0] zone_req,
  input  logic [TIMER_W-1:0]   duration,
  input  logic                 water_ok,
  output logic [NUM_ZONES-1:0] valve,
  output logic                 pump,
  output logic                 busy,
  output logic                 done,
  output logic                 fault,
  output logic [ZW-1:0]        cur_zone
);

  state_e               state, state_d;
  logic [NUM_ZONES-1:0] pending, pending_d;
  logic [TIMER_W-1:0]   dur_reg, dur_d;
  logic [ZW-1:0]        rr_ptr, rr_d;
  logic [ZW-1:0]        zone_d;
  logic                 fault_d;
  logic [NUM_ZONES-1:0] valve_d;
  logic                 pump_d, busy_d, done_d;

  logic [TIMER_W-1:0]   timer;
  logic                 timer_clr;
  logic                 timer_en;
  logic [TIMER_W-1:0]   dur_m1;

  logic                 found;
  logic [ZW-1:0]        sel;
  logic [ZW-1:0]        probe;

  assign timer_en = (state == ST_RUN) && tick;
  assign dur_m1   = dur_reg - TIMER_W'(1);

  zone_timer #(.W(TIMER_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (timer_clr),
    .en    (timer_en),
    .count (timer)
  );

  // First pending zone at or above rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    probe = '0;
    for (int unsigned i = 0; i < NUM_ZONES; i++) begin
      probe = ZW'((32'(rr_ptr) + 32'(i)) % NUM_ZONES);
      if (!found && pending[probe]) begin
        found = 1'b1;
        sel   = probe;
      end
    end
  end

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_d   = state;
    pending_d = pending;
    dur_d     = dur_reg;
    rr_d      = rr_ptr;
    zone_d    = cur_zone;
    fault_d   = fault;
    timer_clr = 1'b0;

    if (state != ST_IDLE && abort) begin
      state_d   = ST_IDLE;
      pending_d = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (water_ok) begin
              pending_d = zone_req;
              dur_d     = duration;
              fault_d   = 1'b0;
              state_d   = ST_SELECT;
            end else begin
              fault_d   = 1'b1;
            end
          end
        end
        ST_SELECT: begin
          if (!found || dur_reg == '0) begin
            state_d = ST_DONE;
          end else begin
            zone_d          = sel;
            pending_d[sel]  = 1'b0;
            timer_clr       = 1'b1;
            state_d         = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!water_ok) begin
            fault_d = 1'b1;
            state_d = ST_IDLE;
          end else if (tick && timer == dur_m1) begin
            state_d = ST_CLOSE;
          end
        end
        ST_CLOSE: begin
          rr_d    = (cur_zone == ZW'(NUM_ZONES - 1)) ? '0 : cur_zone + ZW'(1);
          state_d = ST_SELECT;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    valve_d = (state_d == ST_RUN) ? (NUM_ZONES'(1) << zone_d) : '0;
    pump_d  = (state_d == ST_RUN);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // State, datapath and output registers; reset drops valves immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      pending  <= '0;
      dur_reg  <= '0;
      rr_ptr   <= '0;
      cur_zone <= '0;
      fault    <= 1'b0;
      valve    <= '0;
      pump     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      pending  <= pending_d;
      dur_reg  <= dur_d;
      rr_ptr   <= rr_d;
      cur_zone <= zone_d;
      fault    <= fault_d;
      valve    <= valve_d;
      pump     <= pump_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Bench for irrigation_scheduler: directed scenarios plus random traffic,
// compared every cycle against a queue-based schedule model.
module tb_irrigation_scheduler;

  localparam int NZ = 4;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       start;
  logic       abort;
  logic [3:0] zone_req;
  logic [3:0] duration;
  logic       water_ok;
  logic [3:0] valve;
  logic       pump;
  logic       busy;
  logic       done;
  logic       fault;
  logic [1:0] cur_zone;

  irrigation_scheduler #(.NUM_ZONES(4), .TIMER_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .start    (start),
    .abort    (abort),
    .zone_req (zone_req),
    .duration (duration),
    .water_ok (water_ok),
    .valve    (valve),
    .pump     (pump),
    .busy     (busy),
    .done     (done),
    .fault    (fault),
    .cur_zone (cur_zone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int tick_per = 4;

  // Model: phase 0 idle, 1 choosing, 2 watering, 3 closing, 4 finished.
  int m_ph, m_zone, m_ticks, m_dur, m_rr;
  bit m_fault;
  int m_q[$];

  // Run bookkeeping used by the literal expectations.
  int          rec_done, rec_n, rec_gap_min, rec_gap;
  logic [15:0] rec_order;
  int          rec_ticks[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_zone = 0; m_ticks = 0; m_dur = 0; m_rr = 0; m_fault = 1'b0;
    m_q.delete();
  endtask

  // One clock edge of the scheduling rules, using the inputs the DUT sees.
  task automatic model_edge();
    if (!reset) begin
      model_reset();
    end else if (m_ph == 0) begin
      if (start) begin
        if (water_ok) begin
          m_q.delete();
          if (duration != 4'd0) begin
            for (int k = 0; k < NZ; k++) begin
              int z;
              z = (m_rr + k) % NZ;
              if (zone_req[2'(z)]) m_q.push_back(z);
            end
          end
          m_dur   = int'(duration);
          m_fault = 1'b0;
          m_ph    = 1;
        end else begin
          m_fault = 1'b1;
        end
      end
    end else if (abort) begin
      m_ph = 0;
    end else begin
      case (m_ph)
        1: begin
          if (m_q.size() == 0) m_ph = 4;
          else begin
            m_zone  = m_q.pop_front();
            m_ticks = 0;
            m_ph    = 2;
          end
        end
        2: begin
          if (!water_ok) begin
            m_fault = 1'b1;
            m_ph    = 0;
          end else if (tick) begin
            m_ticks++;
            if (m_ticks == m_dur) m_ph = 3;
          end
        end
        3: begin
          m_rr = (m_zone + 1) % NZ;
          m_ph = 1;
        end
        default: m_ph = 0;
      endcase
    end
  endtask

  task automatic compare_outputs();
    logic [3:0] ev;
    ev = (m_ph == 2) ? 4'(1 << m_zone) : 4'd0;
    check("valve",    32'(valve),    32'(ev));
    check("pump",     32'(pump),     32'(m_ph == 2));
    check("busy",     32'(busy),     32'(m_ph != 0));
    check("done",     32'(done),     32'(m_ph == 4));
    check("fault",    32'(fault),    32'(m_fault));
    check("cur_zone", 32'(cur_zone), 32'(m_zone));
  endtask

  // Advance one cycle, check, then release pulses and pick the next tick.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
    cyc++;
    start = 1'b0;
    abort = 1'b0;
    if (tick_per == 0) tick = ($urandom_range(0, 2) == 0);
    else               tick = ((cyc % tick_per) == 0);
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    int r;
    r = 0;
    for (int z = 0; z < NZ; z++) if (v[z]) r = z;
    return r;
  endfunction

  // Step from the accepting edge until the DUT returns to idle.
  task automatic run_until_idle(input int budget);
    bit prev_on;
    rec_done = 0; rec_n = 0; rec_gap_min = 1000; rec_gap = 0; rec_order = '0;
    for (int z = 0; z < NZ; z++) rec_ticks[z] = 0;
    prev_on = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (valve != 4'd0 && tick) rec_ticks[onehot_idx(valve)]++;
      step();
      if (done) rec_done++;
      if (valve != 4'd0) begin
        if (!prev_on) begin
          if (rec_n > 0 && rec_gap < rec_gap_min) rec_gap_min = rec_gap;
          rec_order = {rec_order[11:0], 4'(onehot_idx(valve))};
          rec_n++;
        end
        rec_gap = 0;
        prev_on = 1'b1;
      end else begin
        rec_gap++;
        prev_on = 1'b0;
      end
      if (!busy) break;
    end
    check("run_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_valve(input int budget);
    for (int i = 0; i < budget && valve == 4'd0; i++) step();
    check("valve_wait_timeout", 32'(valve != 4'd0), 32'd1);
  endtask

  task automatic kick(input logic [3:0] zr, input logic [3:0] dur);
    zone_req = zr;
    duration = dur;
    start    = 1'b1;
  endtask

  initial begin
    int n_done;
    reset = 1'b0; tick = 1'b0; start = 1'b0; abort = 1'b0;
    zone_req = '0; duration = '0; water_ok = 1'b1;
    model_reset();
    #2;
    check("rst_valve", 32'(valve), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    repeat (3) step();
    reset = 1'b1;
    step();
    check("rst_pump",  32'(pump),     32'd0);
    check("rst_done",  32'(done),     32'd0);
    check("rst_fault", 32'(fault),    32'd0);
    check("rst_zone",  32'(cur_zone), 32'd0);

    // Two zones, three ticks each, tick every fourth cycle.
    tick_per = 4;
    kick(4'b0101, 4'd3);
    run_until_idle(200);
    check("norm_done_cnt", 32'(rec_done),     32'd1);
    check("norm_zones",    32'(rec_n),        32'd2);
    check("norm_order",    32'(rec_order),    32'h0002);
    check("norm_ticks_z0", 32'(rec_ticks[0]), 32'd3);
    check("norm_ticks_z2", 32'(rec_ticks[2]), 32'd3);
    check("norm_bbm_gap",  32'(rec_gap_min >= 1), 32'd1);
    step();
    check("norm_idle", 32'(busy), 32'd0);

    // Round robin resumes after zone 2.
    tick_per = 2;
    kick(4'b1111, 4'd1);
    run_until_idle(200);
    check("rr_order",    32'(rec_order), 32'h3012);
    check("rr_zones",    32'(rec_n),     32'd4);
    check("rr_done_cnt", 32'(rec_done),  32'd1);

    // Abort while zone 1 waters.
    tick_per = 4;
    kick(4'b0010, 4'd5);
    step();
    wait_valve(20);
    check("abort_zone", 32'(valve), 32'b0010);
    step(); step();
    abort = 1'b1;
    step();
    check("abort_valve", 32'(valve), 32'd0);
    check("abort_pump",  32'(pump),  32'd0);
    check("abort_busy",  32'(busy),  32'd0);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) n_done++;
      step();
    end
    check("abort_no_done", 32'(n_done), 32'd0);

    // Water shortage mid-run, then a clean restart.
    kick(4'b0100, 4'd5);
    step();
    wait_valve(20);
    water_ok = 1'b0;
    step();
    check("dry_fault", 32'(fault), 32'd1);
    check("dry_valve", 32'(valve), 32'd0);
    check("dry_pump",  32'(pump),  32'd0);
    check("dry_busy",  32'(busy),  32'd0);
    water_ok = 1'b1;
    kick(4'b0001, 4'd2);
    step();
    check("restart_fault", 32'(fault), 32'd0);
    check("restart_busy",  32'(busy),  32'd1);
    run_until_idle(200);
    check("restart_order", 32'(rec_order), 32'h0000);
    check("restart_zones", 32'(rec_n),     32'd1);
    check("restart_done",  32'(rec_done),  32'd1);

    // Start refused while the reservoir is low.
    water_ok = 1'b0;
    kick(4'b1111, 4'd3);
    step();
    check("low_start_fault", 32'(fault), 32'd1);
    check("low_start_busy",  32'(busy),  32'd0);
    water_ok = 1'b1;
    step();

    // Empty runs: no zones, or zero duration.
    kick(4'b0000, 4'd3);
    run_until_idle(50);
    check("empty_mask_done",   32'(rec_done), 32'd1);
    check("empty_mask_valves", 32'(rec_n),    32'd0);
    kick(4'b1111, 4'd0);
    run_until_idle(50);
    check("zero_dur_done",   32'(rec_done), 32'd1);
    check("zero_dur_valves", 32'(rec_n),    32'd0);

    // Asynchronous reset in the middle of watering.
    kick(4'b1000, 4'd15);
    step();
    wait_valve(20);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("arst_valve", 32'(valve), 32'd0);
    check("arst_pump",  32'(pump),  32'd0);
    check("arst_busy",  32'(busy),  32'd0);
    check("arst_fault", 32'(fault), 32'd0);
    step(); step();
    reset = 1'b1;
    step();

    // Random traffic; zone_req/duration wander while runs are in flight.
    tick_per = 0;
    for (int i = 0; i < 4000; i++) begin
      zone_req = 4'($urandom_range(0, 15));
      duration = 4'($urandom_range(0, 5));
      start    = ($urandom_range(0, 7) == 0);
      abort    = ($urandom_range(0, 59) == 0);
      water_ok = ($urandom_range(0, 79) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
